// File: rtl/fp_to_int_arb_pkg.sv
// Shared FPU field widths and bundle types
// for the float-to-int issue arbiter.
package fp_to_int_arb_pkg;

  localparam int OP_W     = 3;
  localparam int RM_W     = 3;
  localparam int FFLAGS_W = 5;
  localparam int XLEN     = 64;
  localparam int TAG_W    = 2;

  typedef logic [TAG_W-1:0] req_tag_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] a;
    logic [RM_W-1:0] rm;
  } fu_req_t;

endpackage

// File: rtl/fp_to_int_arb_tag_fifo.sv
// In-order tag FIFO recording which requester
// owns each operation inside the unit.
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  assign head_o  = r_mem[r_rptr];
  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign empty_o = (r_cnt == '0);

  // Pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
      if (push_i && !pop_i)
        r_cnt <= r_cnt + 1'b1;
      else if (pop_i && !push_i)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Tag storage needs no reset
  always_ff @(posedge clk) begin
    if (push_i) r_mem[r_wptr] <= din_i;
  end

endmodule

// File: rtl/fp_to_int_arb.sv
// Round-robin sharing of one float-to-int unit
// with in-order result steering by tag.
module fp_to_int_arb
  import fp_to_int_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TAGW   = 2,
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*OP_W-1:0]     req_op_i,
  input  logic [NREQ*XLEN-1:0]     req_a_i,
  input  logic [NREQ*RM_W-1:0]     req_rm_i,
  output logic [NREQ-1:0]          rsp_valid_o,
  input  logic [NREQ-1:0]          rsp_ready_i,
  output logic [XLEN-1:0]          rsp_result_o,
  output logic [FFLAGS_W-1:0]      rsp_fflags_o,
  output logic                     fu_in_valid_o,
  input  logic                     fu_in_ready_i,
  output logic [OP_W-1:0]          fu_op_o,
  output logic [XLEN-1:0]          fu_a_o,
  output logic [RM_W-1:0]          fu_rm_o,
  input  logic                     fu_out_valid_i,
  output logic                     fu_out_ready_o,
  input  logic [XLEN-1:0]          fu_result_i,
  input  logic [FFLAGS_W-1:0]      fu_fflags_i,
  output logic                     err_o
);

  // First valid requester at or after the pointer
  function automatic logic [TAGW-1:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [TAGW-1:0] p
  );
    logic [TAGW-1:0] g;
    logic            f;
    int unsigned     k;
    g = '0;
    f = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(p) + i) % NREQ;
      if (!f && v[k]) begin
        g = TAGW'(k);
        f = 1'b1;
      end
    end
    return g;
  endfunction

  logic [TAGW-1:0] r_rr_ptr;
  logic            r_err;
  logic [TAGW-1:0] w_grant;
  logic [TAGW-1:0] w_head;
  logic            w_any;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_can_push;
  logic            w_fire;
  fu_req_t         w_sel;

  assign w_any      = |req_valid_i;
  assign w_grant    = rr_pick(req_valid_i, r_rr_ptr);
  assign w_pop      = fu_out_valid_i && fu_out_ready_o;
  assign w_can_push = !w_full || w_pop;
  assign w_fire     = fu_in_valid_o && fu_in_ready_i;

  assign fu_in_valid_o  = w_any && w_can_push;
  assign fu_out_ready_o = !w_empty && rsp_ready_i[w_head];
  assign fu_op_o        = w_sel.op;
  assign fu_a_o         = w_sel.a;
  assign fu_rm_o        = w_sel.rm;
  assign rsp_result_o   = fu_result_i;
  assign rsp_fflags_o   = fu_fflags_i;
  assign err_o          = r_err;

  // Request mux and one-hot accept
  always_comb begin
    w_sel       = '0;
    req_ready_o = '0;
    if (w_any) begin
      w_sel.op = req_op_i[w_grant*OP_W +: OP_W];
      w_sel.a  = req_a_i[w_grant*XLEN +: XLEN];
      w_sel.rm = req_rm_i[w_grant*RM_W +: RM_W];
      req_ready_o[w_grant] = fu_in_ready_i && w_can_push;
    end
  end

  // Steer the unit result to the tag owner
  always_comb begin
    rsp_valid_o = '0;
    if (fu_out_valid_i && !w_empty)
      rsp_valid_o[w_head] = 1'b1;
  end

  // Pointer moves past the winner on each issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      if (w_grant == TAGW'(NREQ-1))
        r_rr_ptr <= '0;
      else
        r_rr_ptr <= w_grant + 1'b1;
    end
  end

  // A result with no owner is a sticky fault
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (fu_out_valid_i && w_empty)
      r_err <= 1'b1;
  end

  tag_fifo #(
    .W     (TAGW),
    .DEPTH (QDEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_fire),
    .pop_i   (w_pop),
    .din_i   (w_grant),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: tb/tb_fp_to_int_arb.sv
// Bench for fp_to_int_arb: 2-stage unit model
// plus an in-order response scoreboard.
module tb_fp_to_int_arb;

  localparam int NREQ = 4;
  localparam int QD   = 4;

  typedef struct {
    int          idx;
    logic [63:0] res;
    logic [4:0]  ff;
  } exp_t;

  logic            clk = 0;
  logic            rst = 1;
  logic [3:0]      req_valid = '0;
  logic [3:0]      req_ready;
  logic [11:0]     req_op = '0;
  logic [255:0]    req_a = '0;
  logic [11:0]     req_rm = '0;
  logic [3:0]      rsp_valid;
  logic [3:0]      rsp_ready = '1;
  logic [63:0]     rsp_result;
  logic [4:0]      rsp_fflags;
  logic            fu_in_valid, fu_in_ready;
  logic [2:0]      fu_op, fu_rm;
  logic [63:0]     fu_a;
  logic            fu_out_valid, fu_out_ready;
  logic [63:0]     fu_result;
  logic [4:0]      fu_fflags;
  logic            err;
  logic            stray = 0;

  logic            s1_v, s2_v;
  logic [63:0]     s1_r, s2_r;
  logic [4:0]      s1_f, s2_f;
  logic            s2_rdy;

  int   checks = 0;
  int   errors = 0;
  int   n_fire = 0;
  int   tb_rr  = 0;
  bit   mon_en = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [63:0] conv(input logic [63:0] a);
    int e;
    logic [63:0] m;
    e = int'(a[30:23]);
    if (e < 127 || e > 150) return 64'h7fff_ffff;
    m = {40'd0, 1'b1, a[22:0]} >> (150 - e);
    return a[31] ? -m : m;
  endfunction

  function automatic logic [4:0] cflags(input logic [63:0] a);
    int e;
    e = int'(a[30:23]);
    return (e < 127 || e > 150) ? 5'b10000 : 5'b00000;
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  assign s2_rdy       = !s2_v || fu_out_ready;
  assign fu_in_ready  = !s1_v || s2_rdy;
  assign fu_out_valid = s2_v | stray;
  assign fu_result    = s2_r;
  assign fu_fflags    = s2_f;

  // Stand-in for the 2-stage conversion unit
  always @(posedge clk) begin
    if (rst) begin
      s1_v <= 0;
      s2_v <= 0;
    end else begin
      if (s2_rdy) begin
        s2_v <= s1_v;
        s2_r <= s1_r;
        s2_f <= s1_f;
      end
      if (fu_in_ready) begin
        s1_v <= fu_in_valid;
        s1_r <= conv(fu_a);
        s1_f <= cflags(fu_a);
      end
    end
  end

  fp_to_int_arb #(.NREQ(4), .TAGW(2), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_rm_i(req_rm),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_fflags_o(rsp_fflags),
    .fu_in_valid_o(fu_in_valid), .fu_in_ready_i(fu_in_ready),
    .fu_op_o(fu_op), .fu_a_o(fu_a), .fu_rm_o(fu_rm),
    .fu_out_valid_i(fu_out_valid), .fu_out_ready_o(fu_out_ready),
    .fu_result_i(fu_result), .fu_fflags_i(fu_fflags),
    .err_o(err)
  );

  logic [3:0]  d2_valid = '0, d2_ready, d2_rsp_valid;
  logic [3:0]  d2_rsp_ready = '1;
  logic        d2_in_valid, d2_out_valid = 0, d2_out_ready, d2_err;
  logic [2:0]  d2_op, d2_rm;
  logic [63:0] d2_a, d2_res;
  logic [4:0]  d2_ff;

  fp_to_int_arb #(.NREQ(4), .TAGW(2), .QDEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(d2_valid), .req_ready_o(d2_ready),
    .req_op_i(12'd0), .req_a_i(256'd0), .req_rm_i(12'd0),
    .rsp_valid_o(d2_rsp_valid), .rsp_ready_i(d2_rsp_ready),
    .rsp_result_o(d2_res), .rsp_fflags_o(d2_ff),
    .fu_in_valid_o(d2_in_valid), .fu_in_ready_i(1'b1),
    .fu_op_o(d2_op), .fu_a_o(d2_a), .fu_rm_o(d2_rm),
    .fu_out_valid_i(d2_out_valid), .fu_out_ready_o(d2_out_ready),
    .fu_result_i(64'd0), .fu_fflags_i(5'd0),
    .err_o(d2_err)
  );

  // Scoreboard: predict accept/steer each cycle
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      bit   pop;
      bit   cp;
      int   g;
      logic [3:0] er;
      pop = 0;
      checks++;
      if (q.size() == 0) begin
        if (rsp_valid !== 4'b0 || fu_out_ready !== 1'b0) begin
          errors++;
          $display("FAIL rsp_empty: rsp_valid=%b out_ready=%b want 0/0",
                   rsp_valid, fu_out_ready);
        end
      end else begin
        er = fu_out_valid ? 4'(1 << q[0].idx) : 4'b0;
        if (rsp_valid !== er ||
            fu_out_ready !== rsp_ready[q[0].idx]) begin
          errors++;
          $display("FAIL rsp_steer: rsp_valid=%b rdy=%b want %b/%b",
                   rsp_valid, fu_out_ready, er, rsp_ready[q[0].idx]);
        end
        pop = fu_out_valid && rsp_ready[q[0].idx];
        if (pop) begin
          checks++;
          if (rsp_result !== q[0].res || rsp_fflags !== q[0].ff) begin
            errors++;
            $display("FAIL rsp_data: got %h/%b want %h/%b (req %0d)",
                     rsp_result, rsp_fflags, q[0].res, q[0].ff, q[0].idx);
          end
          void'(q.pop_front());
        end
      end
      cp = (q.size() < QD) || pop;
      g  = pick(req_valid, tb_rr);
      er = ((|req_valid) && fu_in_ready && cp) ? 4'(1 << g) : 4'b0;
      checks++;
      if (req_ready !== er || fu_in_valid !== ((|req_valid) && cp)) begin
        errors++;
        $display("FAIL issue: req_ready=%b in_valid=%b want %b/%b",
                 req_ready, fu_in_valid, er, (|req_valid) && cp);
      end
      if (er != 0) begin
        checks++;
        if (fu_a !== req_a[g*64 +: 64]) begin
          errors++;
          $display("FAIL issue_a: got %h want %h", fu_a, req_a[g*64 +: 64]);
        end
        q.push_back('{g, conv(req_a[g*64 +: 64]),
                      cflags(req_a[g*64 +: 64])});
        tb_rr = (g + 1) % NREQ;
        n_fire++;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      logic [7:0] e;
      e = 8'($urandom_range(120, 155));
      req_a[i*64 +: 64] = {32'hffff_ffff, 1'($urandom), e,
                           23'($urandom)};
      req_op[i*3 +: 3] = 3'($urandom);
      req_rm[i*3 +: 3] = 3'($urandom);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      cyc();
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outstanding want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(2);
    checks++;
    if (req_ready !== 0 || rsp_valid !== 0 || err !== 0 ||
        fu_in_valid !== 0 || fu_out_ready !== 0) begin
      errors++;
      $display("FAIL reset: rdy=%b rsp=%b err=%b want 0",
               req_ready, rsp_valid, err);
    end
    rst = 0;
    tb_rr = 0;
    mon_en = 1;
  endtask

  task automatic test_single();
    req_a[2*64 +: 64] = 64'hffff_ffff_4040_0000;
    req_op[2*3 +: 3]  = 3'd0;
    req_rm[2*3 +: 3]  = 3'd0;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    cyc();
    req_valid = 0;
    cyc();
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_result !== 64'd3) begin
      errors++;
      $display("FAIL single_rsp: got %b/%0d want 0100/3",
               rsp_valid, rsp_result);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int st;
    set_ops();
    st = tb_rr;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (req_ready !== 4'(1 << ((st + i) % NREQ))) begin
        errors++;
        $display("FAIL b2b_grant%0d: got %b want %b", i, req_ready,
                 4'(1 << ((st + i) % NREQ)));
      end
      cyc();
    end
    req_valid = 0;
    wait_drain();
  endtask

  task automatic test_head_stall();
    set_ops();
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    cyc();
    n_fire = 1;
    req_valid = 4'b1111;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 4'b0001 || fu_out_ready !== 0 ||
          req_ready !== 0) begin
        errors++;
        $display("FAIL stall_hold: rsp=%b ordy=%b rdy=%b want 0001/0/0",
                 rsp_valid, fu_out_ready, req_ready);
      end
      cyc();
    end
    checks++;
    if (n_fire != 2) begin
      errors++;
      $display("FAIL stall_issues: got %0d want 2", n_fire);
    end
    req_valid = 0;
    rsp_ready = 4'b1111;
    wait_drain();
  endtask

  task automatic test_full_fifo();
    d2_valid = 4'b0001;
    cyc(2);
    checks++;
    if (d2_ready !== 0 || d2_in_valid !== 0) begin
      errors++;
      $display("FAIL full_block: rdy=%b in_valid=%b want 0/0",
               d2_ready, d2_in_valid);
    end
    d2_out_valid = 1;
    #1;
    checks++;
    if (d2_ready !== 4'b0001 || d2_rsp_valid !== 4'b0001 ||
        d2_out_ready !== 1) begin
      errors++;
      $display("FAIL full_pop_push: rdy=%b rsp=%b want 0001/0001",
               d2_ready, d2_rsp_valid);
    end
    cyc();
    d2_out_valid = 0;
    #1;
    checks++;
    if (d2_ready !== 0) begin
      errors++;
      $display("FAIL full_count: rdy=%b want 0000", d2_ready);
    end
    d2_valid = 0;
    d2_out_valid = 1;
    cyc(2);
    d2_out_valid = 0;
    #1;
    checks++;
    if (d2_out_ready !== 0 || d2_err !== 0 || d2_rsp_valid !== 0) begin
      errors++;
      $display("FAIL full_drain: ordy=%b err=%b want 0/0",
               d2_out_ready, d2_err);
    end
  endtask

  task automatic test_stray();
    stray = 1;
    #1;
    checks++;
    if (rsp_valid !== 0 || fu_out_ready !== 0 || err !== 0) begin
      errors++;
      $display("FAIL stray_now: rsp=%b ordy=%b err=%b want 0/0/0",
               rsp_valid, fu_out_ready, err);
    end
    cyc();
    stray = 0;
    cyc(3);
    checks++;
    if (err !== 1) begin
      errors++;
      $display("FAIL stray_sticky: err=%b want 1", err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_ops();
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom) | 4'($urandom);
      cyc();
    end
    req_valid = 0;
    rsp_ready = 4'b1111;
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    set_ops();
    req_valid = 4'b1010;
    cyc(2);
    req_valid = 0;
    rst = 1;
    cyc();
    q.delete();
    tb_rr = 0;
    checks++;
    if (req_ready !== 0 || rsp_valid !== 0 || err !== 0 ||
        fu_out_ready !== 0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b rsp=%b err=%b want 0",
               req_ready, rsp_valid, err);
    end
    rst = 0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_rrptr: got %b want 0001", req_ready);
    end
    cyc();
    req_valid = 0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_head_stall();
    test_full_fifo();
    test_stray();
    test_random();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_to_int_arb.md
# fp_to_int_arb

Round-robin arbiter that shares one 2-stage float-to-int conversion pipeline (`fp_to_int_no_ctrl`) among `NREQ` requesters, e.g. per-warp FPU issue slots in an SM. It serialises requests into the unit and keeps an in-order tag FIFO of outstanding operations. It steers each result and its fflags back to the requester that issued it. Per-requester backpressure is propagated into the unit's output stage.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `TAGW`, 2: requester-index width, `$clog2(NREQ)`.
- `QDEPTH`, 4: tag FIFO depth, power of 2, ≥ unit latency (2).

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid_i`  in  NREQ: request valid per requester.
- `req_ready_o`  out  NREQ: request accepted, one-hot or zero.
- `req_op_i`  in  NREQ*3: op per requester; requester i in bits `[3i+2:3i]`.
- `req_a_i`  in  NREQ*64: source operand per requester.
- `req_rm_i`  in  NREQ*3: rounding mode per requester.
- `rsp_valid_o`  out  NREQ: result valid, one-hot or zero.
- `rsp_ready_i`  in  NREQ: result ready per requester.
- `rsp_result_o`  out  64: shared result bus.
- `rsp_fflags_o`  out  5: shared fflags bus.
- `fu_in_valid_o` / `fu_in_ready_i`  out/in  1: unit input handshake.
- `fu_op_o`, `fu_a_o`, `fu_rm_o`  out  3/64/3: muxed request fields.
- `fu_out_valid_i` / `fu_out_ready_o`  in/out  1: unit output handshake.
- `fu_result_i`, `fu_fflags_i`  in  64/5: unit result.
- `err_o`  out  1: sticky protocol error.

## Operation
- **Arbitration**
  - `grant` is the first requester with `req_valid_i` set, searching from `rr_ptr` upward with wrap.
  - `grant` depends only on `req_valid_i` and `rr_ptr`, never on any ready signal.
  - `fu_in_valid_o = |req_valid_i && can_push`.
  - `fu_op_o`, `fu_a_o` and `fu_rm_o` come from the granted requester; they are 0 when nothing is valid.
  - `req_ready_o[grant] = fu_in_ready_i && can_push`; all other bits are 0.
- **Issue fire** (`fu_in_valid_o && fu_in_ready_i`):
  - push `grant` into the tag FIFO;
  - `rr_ptr <= grant+1` mod NREQ.
  - With no fire, `rr_ptr` holds.
- **can_push** = FIFO not full, or FIFO full with a pop in the same cycle.
- **Response path**
  - `head` is the FIFO head tag.
  - `rsp_valid_o[head] = fu_out_valid_i && !empty`.
  - `fu_out_ready_o = rsp_ready_i[head] && !empty`.
  - `rsp_result_o` / `rsp_fflags_o` pass `fu_result_i` / `fu_fflags_i` through unchanged.
  - Pop on `fu_out_valid_i && fu_out_ready_o`.
- **Simultaneous push and pop**
  - count is unchanged; both pointers advance.
  - Legal when full or empty. When empty, the push cannot be the pop, because the unit latency is ≥1 cycle.
- **Error**: `fu_out_valid_i` while the FIFO is empty sets `err_o`.
  - `err_o` is held until `rst`.
  - The stray result is not forwarded, and `fu_out_ready_o=0`.
- **Reset**
  - `rr_ptr=0`, FIFO empty, `err_o=0`.
  - All `req_ready_o` and `rsp_valid_o` are 0.
  - Reset mid-operation discards outstanding tags. The unit must be reset in the same cycle.

## Timing
- Request and response muxing are purely combinational; the arbiter adds 0 cycles.
- End-to-end latency equals the unit latency: 2 cycles from issue fire to `rsp_valid_o` when unstalled.
- Sustains 1 issue per cycle while FIFO occupancy stays below `QDEPTH`.
- A stalled head requester (`rsp_ready_i=0`) stalls the unit output. Via the unit's ready chain, this blocks all issue after 2 in-flight operations (head-of-line blocking is accepted).
- FIFO count range is 0..QDEPTH; pointers are `$clog2(QDEPTH)` bits and wrap naturally.

## Structure
- Shared FPU package holds the op-field width (3), rm width (3), fflags width (5) and the requester-tag typedef.
- One sub-module, `tag_fifo`: synchronous FIFO, parameterised width/depth, with push/pop/full/empty/head.
- The round-robin pick is a function inside the arbiter.

## Test plan
- **Single requester.** Only req 2 valid, `a=0x40400000` (3.0f), FCVT.W.S op, `rm=0`, all ready. Expected: `req_ready_o=4'b0100` in cycle 0; `rsp_valid_o=4'b0100` in cycle 2 with `result=3`.
- **All four requesters, back-to-back.** All valid continuously, all ready. Expected grants 0,1,2,3,0,…, one per cycle; each result returns to the issuing index in the same order.
- **Head stall.** `rsp_ready_i[0]=0` with req 0 at the head. Expected:
  - `fu_out_ready_o=0`;
  - issue stops after occupancy reaches 2;
  - no grant beyond that; `rsp_valid_o` holds `4'b0001` steady.
  - Releasing it drains the results in order.
- **Full FIFO.** Set `QDEPTH=2` and hold the unit input ready. Check `req_ready_o=0` when count=2 with no pop, and an accept on the cycle when a pop coincides.
- **Stray result.** Drive `fu_out_valid_i=1` with the FIFO empty. Expected: `err_o` rises the next cycle and stays 1; `rsp_valid_o=0`.
- **Reset mid-flight.** Assert `rst` with 2 outstanding. Next cycle: count=0, `rr_ptr=0`, all outputs 0, `err_o=0`.
